apb_master_bridge: RTL and testbench

- APB requester: converts a single-beat command interface (valid/ready) into APB transfers toward two APB completers (slave1, slave2) sharing one bus.
- Drives PADDR/PWDATA/PWRITE/PENABLE and per-slave PSEL; returns read data and completion status on a response port.
- Contains the IDLE/SETUP/ACCESS state machine, the address decode that selects a slave, and a wait-state timeout.
- Sits between the system-side controller or testbench driver and the APB completers.

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to two-completer APB requester with address decode and wait-state timeout
module apb_master_bridge #(
  parameter int WIDTH   = 32,
  parameter int SEL_BIT = 7,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_error,
  output logic [WIDTH-1:0] PADDR,
  output logic [WIDTH-1:0] PWDATA,
  output logic             PWRITE,
  output logic             PENABLE,
  output logic             PSEL1,
  output logic             PSEL2,
  input  logic             PREADY1,
  input  logic             PREADY2,
  input  logic [WIDTH-1:0] PRDATA1,
  input  logic [WIDTH-1:0] PRDATA2
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic pwrite_q, pwrite_d, penable_q, penable_d, psel1_q, psel1_d, psel2_q, psel2_d;
  logic rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic pready;
  logic [WIDTH-1:0] prdata;
  assign pready = psel2_q ? PREADY2 : PREADY1;
  assign prdata = psel2_q ? PRDATA2 : PRDATA1;
  assign cmd_ready = (state_q == IDLE) && PRESETn;
  assign PADDR = paddr_q;
  assign PWDATA = pwdata_q;
  assign PWRITE = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL1 = psel1_q;
  assign PSEL2 = psel2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    penable_d = penable_q;
    psel1_d = psel1_q;
    psel2_d = psel2_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = SETUP;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          paddr_d = cmd_addr;
          paddr_d[SEL_BIT] = 1'b0;
          psel1_d = !cmd_addr[SEL_BIT];
          psel2_d = cmd_addr[SEL_BIT];
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: begin
        if (pready || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          psel1_d = 1'b0;
          psel2_d = 1'b0;
          penable_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = !pready;
          rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        psel1_d = 1'b0;
        psel2_d = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      penable_q <= 1'b0;
      psel1_q <= 1'b0;
      psel2_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      penable_q <= penable_d;
      psel1_q <= psel1_d;
      psel2_q <= psel2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed self-checking bench with two registered-PREADY memory completers
module tb_apb_master_bridge;
  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_error, PWRITE, PENABLE, PSEL1, PSEL2;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA1, PRDATA2;
  logic PREADY1 = 1'b0, PREADY2 = 1'b0, stall1 = 1'b0;
  logic [31:0] mem1 [128];
  logic [31:0] mem2 [128];
  int checks = 0, errors = 0;
  int lat;
  logic [31:0] rd;
  logic err, s_psel1, s_psel2, s_penable, a_penable, pwrite_seen;
  logic [31:0] s_paddr;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PREADY1(PREADY1), .PREADY2(PREADY2),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  always #5 PCLK = ~PCLK;

  assign PRDATA1 = mem1[PADDR[6:0]];
  assign PRDATA2 = mem2[PADDR[6:0]];

  initial for (int i = 0; i < 128; i++) begin
    mem1[i] = '0;
    mem2[i] = '0;
  end

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      PREADY1 <= 1'b0;
      PREADY2 <= 1'b0;
    end else begin
      PREADY1 <= PSEL1 && PENABLE && !PREADY1 && !stall1;
      PREADY2 <= PSEL2 && PENABLE && !PREADY2;
      if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR[6:0]] <= PWDATA;
      if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR[6:0]] <= PWDATA;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    check("cmd_ready_before", {31'b0, cmd_ready}, 32'd1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    s_psel1 = PSEL1;
    s_psel2 = PSEL2;
    s_penable = PENABLE;
    s_paddr = PADDR;
    pwrite_seen = PWRITE;
    a_penable = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge PCLK);
      lat = n;
      if (n == 1) a_penable = PENABLE;
      if (rsp_valid) break;
      pwrite_seen = pwrite_seen | PWRITE;
    end
    rd = rsp_rdata;
    err = rsp_error;
    check("psel_drop_on_rsp", {30'b0, PSEL1, PSEL2}, 32'd0);
    @(negedge PCLK);
    check("rsp_valid_one_cycle", {31'b0, rsp_valid}, 32'd0);
    check("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    cmd_valid = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_psel", {30'b0, PSEL1, PSEL2}, 32'd0);
    check("rst_penable_pwrite", {30'b0, PENABLE, PWRITE}, 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_rsp", {30'b0, rsp_valid, rsp_error}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    PRESETn = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    issue(1'b1, 32'h05, 32'hDEADBEEF);
    check("w1_setup_psel", {30'b0, s_psel1, s_psel2}, 32'b10);
    check("w1_setup_penable", {31'b0, s_penable}, 32'd0);
    check("w1_paddr", s_paddr, 32'h05);
    check("w1_access_penable", {31'b0, a_penable}, 32'd1);
    check("w1_latency", lat, 32'd3);
    check("w1_err", {31'b0, err}, 32'd0);
    check("w1_rdata", rd, 32'd0);

    issue(1'b0, 32'h05, 32'h0);
    check("r1_rdata", rd, 32'hDEADBEEF);
    check("r1_pwrite", {31'b0, pwrite_seen}, 32'd0);
    check("r1_latency", lat, 32'd3);

    issue(1'b1, 32'h83, 32'h12345678);
    check("w2_setup_psel", {30'b0, s_psel1, s_psel2}, 32'b01);
    check("w2_paddr", s_paddr, 32'h03);
    check("w2_err", {31'b0, err}, 32'd0);
    issue(1'b0, 32'h83, 32'h0);
    check("r2_rdata", rd, 32'h12345678);
    check("r2_psel", {30'b0, s_psel1, s_psel2}, 32'b01);
    issue(1'b0, 32'h03, 32'h0);
    check("r1_03_rdata", rd, 32'd0);
    check("r1_03_psel", {30'b0, s_psel1, s_psel2}, 32'b10);

    stall1 = 1'b1;
    issue(1'b0, 32'h10, 32'h0);
    check("to_latency", lat, 32'd17);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_rdata", rd, 32'd0);
    stall1 = 1'b0;

    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h20;
    cmd_wdata = 32'hCAFEF00D;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("mid_penable_before", {31'b0, PENABLE}, 32'd1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("mid_psel_penable", {29'b0, PSEL1, PSEL2, PENABLE}, 32'd0);
    check("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("mid_no_rsp_after", {31'b0, rsp_valid}, 32'd0);
    issue(1'b1, 32'h20, 32'h0BADF00D);
    check("post_w_latency", lat, 32'd3);
    check("post_w_err", {31'b0, err}, 32'd0);
    issue(1'b0, 32'h20, 32'h0);
    check("post_r_rdata", rd, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
